// File: rtl/skip_pkg.sv
// Shared types and widths for the clock-skip sequencer: channel modes and
// small helpers used by the channel and top-level logic.
package skip_pkg;

    localparam int MODEW = 2;
    localparam int CNTW  = 8;

    typedef enum logic [MODEW-1:0] {
        MODE_OFF     = 2'd0,
        MODE_CONT    = 2'd1,
        MODE_ONESHOT = 2'd2,
        MODE_HOLD    = 2'd3
    } mode_e;

    // A channel is busy in every mode except OFF.
    function automatic logic mode_busy(input mode_e m);
        return m != MODE_OFF;
    endfunction

    // CONT and ONESHOT step through the ring; HOLD repeats one position.
    function automatic logic mode_advances(input mode_e m);
        return (m == MODE_CONT) || (m == MODE_ONESHOT);
    endfunction

    // Channel-select width, kept at least one bit for a single channel.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/skip_seq_if.sv
// Configuration load bus of skip_seq: valid/ready handshake carrying the
// target channel, mode, skip mask and ONESHOT revolution count.
interface skip_seq_if #(
    parameter int CH  = 4,
    parameter int LEN = 16
);
    import skip_pkg::*;

    localparam int CHW = sel_width(CH);

    logic                 iLD_VALID;
    logic                 oLD_READY;
    logic [CHW-1:0]       iLD_CH;
    logic [MODEW-1:0]     iLD_MODE;
    logic [LEN-1:0]       iLD_MASK;
    logic [CNTW-1:0]      iLD_CNT;

    modport master (
        output iLD_VALID,
        output iLD_CH,
        output iLD_MODE,
        output iLD_MASK,
        output iLD_CNT,
        input  oLD_READY
    );

    modport slave (
        input  iLD_VALID,
        input  iLD_CH,
        input  iLD_MODE,
        input  iLD_MASK,
        input  iLD_CNT,
        output oLD_READY
    );

endinterface

// File: rtl/skip_chan.sv
// One sequencer channel: mode, skip mask, ring position and revolution count,
// advanced by the shared tick and overwritten by a load strobe.
module skip_chan
    import skip_pkg::*;
#(
    parameter int LEN = 16
) (
    input  logic            iCLK,
    input  logic            iRST,
    input  logic            tick,
    input  logic            ld,
    input  mode_e           ld_mode,
    input  logic [LEN-1:0]  ld_mask,
    input  logic [CNTW-1:0] ld_cnt,
    output logic            en,
    output logic            st,
    output logic            busy,
    output logic            done
);

    localparam int PTRW = $clog2(LEN);

    mode_e           mode;
    logic [LEN-1:0]  mask;
    logic [PTRW-1:0] ptr;
    logic [CNTW-1:0] rc;
    logic            wrap;

    assign wrap = (ptr == PTRW'(LEN - 1));

    // NOTE: all state, including the mask, is cleared by reset so the
    // channel comes out of reset in a defined OFF state; sequential state
    // uses non-blocking assignments only.
    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            mode <= MODE_OFF;
            mask <= '0;
            ptr  <= '0;
            rc   <= '0;
            en   <= 1'b0;
            st   <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            en   <= 1'b0;
            st   <= 1'b0;
            done <= 1'b0;

            if (tick && mode_busy(mode)) begin
                en <= ~mask[ptr];
                st <= (ptr == '0);
                if (mode_advances(mode)) begin
                    ptr <= wrap ? '0 : ptr + 1'b1;
                    if (wrap && mode == MODE_ONESHOT) begin
                        if (rc == '0) begin
                            mode <= MODE_OFF;
                            busy <= 1'b0;
                            done <= 1'b1;
                        end else begin
                            rc <= rc - 1'b1;
                        end
                    end
                end
            end

            // A load lands after the tick above, so that tick used the old
            // configuration and the new one takes over from ptr 0.
            if (ld) begin
                mode <= ld_mode;
                mask <= ld_mask;
                rc   <= ld_cnt;
                ptr  <= '0;
                busy <= mode_busy(ld_mode);
            end
        end
    end

endmodule

// File: rtl/skip_seq.sv
// Multi-channel clock-skip sequencer: a shared prescaler tick drives CH
// independent mask rings, each emitting one-cycle enables or skipping them.
module skip_seq
    import skip_pkg::*;
#(
    parameter int CH   = 4,
    parameter int LEN  = 16,
    parameter int DIVW = 32
) (
    input  logic            iCLK,
    input  logic            iRST,
    input  logic            iE,
    input  logic [DIVW-1:0] iDIV,
    skip_seq_if.slave       ld,
    output logic [CH-1:0]   oEN,
    output logic [CH-1:0]   oST,
    output logic [CH-1:0]   oBUSY,
    output logic [CH-1:0]   oDONE
);

    localparam int CHW = sel_width(CH);

    logic [DIVW-1:0] pc;
    logic            tick_q;
    logic            ld_fire;

    // Loads are never stalled; only reset closes the port.
    assign ld.oLD_READY = iRST;
    assign ld_fire      = ld.iLD_VALID && ld.oLD_READY;

    // The tick decision is registered; channels act on it one edge later.
    // Using >= lets a lowered iDIV take effect on the next active cycle.
    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            pc     <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            if (iE) begin
                if (pc >= iDIV) begin
                    tick_q <= 1'b1;
                    pc     <= '0;
                end else begin
                    pc <= pc + 1'b1;
                end
            end
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic ld_stb;

        // Channel numbers at or above CH match no instance and are dropped.
        assign ld_stb = ld_fire && (ld.iLD_CH == CHW'(c));

        skip_chan #(
            .LEN (LEN)
        ) u_chan (
            .iCLK    (iCLK),
            .iRST    (iRST),
            .tick    (tick_q),
            .ld      (ld_stb),
            .ld_mode (mode_e'(ld.iLD_MODE)),
            .ld_mask (ld.iLD_MASK),
            .ld_cnt  (ld.iLD_CNT),
            .en      (oEN[c]),
            .st      (oST[c]),
            .busy    (oBUSY[c]),
            .done    (oDONE[c])
        );
    end

endmodule
